// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths:
// FSM state codes, data width and bit-timer width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO with show-ahead head data; a push and a pop on one edge keep the count.
// Writes while full are ignored; the reader must only pop when not empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [UART_DATA_BITS-1:0]   wr_data_i,
  input  logic                        rd_en_i,
  output logic [UART_DATA_BITS-1:0]   rd_data_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        empty_o,
  output logic                        full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [PTR_W:0]            count_q;
  logic                      push;
  logic                      pop;

  assign full_o    = (count_q == DEPTH_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign push      = wr_en_i & ~full_o;
  assign pop       = rd_en_i & ~empty_o;

  // Storage has no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter behind a byte FIFO; a byte accepted while idle starts its start bit one edge later.
// o_Tx_Ready is low while the FIFO is full, and writes presented then are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W   = $clog2(UART_DATA_BITS);
  localparam logic [FCNT_W-1:0]     FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);
  localparam logic [UART_CNT_W-1:0] CNT_LAST      = UART_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_CNT_W-1:0] CNT_ONE       = UART_CNT_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST      = IDX_W'(UART_DATA_BITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE       = IDX_W'(1);

  uart_state_e               state_q, state_d;
  logic [UART_CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      serial_q, serial_d;
  logic                      active_q, active_d;
  logic                      done_q, done_d;

  logic                      pop;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic [FCNT_W-1:0]         fifo_count;
  logic                      fifo_empty;
  logic                      fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_Clock),
    .rst_i     (i_rst),
    .wr_en_i   (i_Tx_DV & ~fifo_full),
    .wr_data_i (i_Tx_Byte),
    .rd_en_i   (pop),
    .rd_data_o (fifo_data),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  // Registered count: a full FIFO still refuses a write on the edge it pops.
  assign o_Tx_Ready  = (fifo_count != FIFO_FULL_CNT);
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        serial_d  = 1'b1;
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_data;
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          serial_d = shift_q[0];
          state_d  = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            serial_d  = 1'b1;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
            serial_d  = shift_q[bit_idx_q + IDX_ONE];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = S_CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CLEANUP: begin
        serial_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: framing, FIFO burst and backpressure, write on the pop edge,
// asynchronous reset mid-frame, and a loopback into a behavioural receiver at full bit time.
module tb_uart_tx;

  localparam int CA  = 4;
  localparam int CB  = 434;
  localparam int GAP = 10 * CA + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv_a = 1'b0;
  logic [7:0] byte_a = 8'h00;
  logic       rdy_a, ser_a, act_a, done_a;
  logic       dv_b = 1'b0;
  logic [7:0] byte_b = 8'h00;
  logic       rdy_b, ser_b, act_b, done_b;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CA), .FIFO_DEPTH(4)) u_dut_a (
    .i_Clock(clk), .i_rst(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
    .o_Tx_Ready(rdy_a), .o_Tx_Serial(ser_a), .o_Tx_Active(act_a), .o_Tx_Done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(CB), .FIFO_DEPTH(4)) u_dut_b (
    .i_Clock(clk), .i_rst(rst), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
    .o_Tx_Ready(rdy_b), .o_Tx_Serial(ser_b), .o_Tx_Active(act_b), .o_Tx_Done(done_b)
  );

  int         n_checks = 0;
  int         n_fails  = 0;
  int         n_done_b;
  logic       cap_ser[$];
  logic       cap_done[$];
  logic       cap_act[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  logic [7:0] lb [4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cap_ser.push_back(ser_a);
    cap_done.push_back(done_a);
    cap_act.push_back(act_a);
  endtask

  task automatic clear_cap();
    cap_ser.delete();
    cap_done.delete();
    cap_act.delete();
  endtask

  function automatic int at(input int sel, input int j);
    if (j < 0 || j >= cap_ser.size()) return -1;
    case (sel)
      0:       return int'(cap_ser[j]);
      1:       return int'(cap_done[j]);
      default: return int'(cap_act[j]);
    endcase
  endfunction

  function automatic int frame_lvl(input logic [7:0] b, input int k);
    if (k == 0) return 0;
    if (k == 9) return 1;
    return int'(b[k-1]);
  endfunction

  // Decodes the captured DUT A samples against exp_q: start latency, per-cycle levels,
  // Active/Done shape, spacing between frames and a quiet line afterwards.
  task automatic check_frames(input string tag, input int first_start);
    int s = -1;
    int nxt;
    int mism;
    int tail;
    int zeros = 0;
    int dones = 0;
    for (int j = 0; j < cap_ser.size(); j++)
      if (s < 0 && cap_ser[j] == 1'b0) s = j;
    check({tag, "_lat"}, s, first_start);
    if (s < 0) return;
    tail = s;
    for (int f = 0; f < exp_q.size(); f++) begin
      mism = 0;
      for (int i = 0; i < 10 * CA; i++) begin
        if (at(0, s + i) != frame_lvl(exp_q[f], i / CA)) mism++;
        if (at(1, s + i) != 0 || at(2, s + i) != 1) mism++;
      end
      if (at(1, s + 10*CA) != 1 || at(2, s + 10*CA) != 0 || at(0, s + 10*CA) != 1) mism++;
      if (at(1, s + 10*CA + 1) != 0 || at(0, s + 10*CA + 1) != 1) mism++;
      check($sformatf("%s_frame%0d_%02h", tag, f, exp_q[f]), mism, 0);
      tail = s + 10*CA + 2;
      if (f < exp_q.size() - 1) begin
        nxt = -1;
        for (int j = s + 10*CA; j < cap_ser.size(); j++)
          if (nxt < 0 && cap_ser[j] == 1'b0) nxt = j;
        check({tag, "_gap"}, nxt - s, GAP);
        if (nxt < 0) return;
        s = nxt;
      end
    end
    for (int j = tail; j < cap_ser.size(); j++)
      if (cap_ser[j] != 1'b1) zeros++;
    check({tag, "_idle_after"}, zeros, 0);
    for (int j = 0; j < cap_done.size(); j++)
      if (cap_done[j] == 1'b1) dones++;
    check({tag, "_done_cnt"}, dones, exp_q.size());
  endtask

  // Behavioural receiver for DUT B: mid-bit sampling, one push per good frame.
  always begin
    @(posedge clk);
    #1;
    if (!rst && ser_b == 1'b0) begin
      repeat (CB / 2) @(posedge clk);
      #1;
      if (ser_b == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CB) @(posedge clk);
          #1;
          rx_b[i] = ser_b;
        end
        repeat (CB) @(posedge clk);
        #1;
        if (ser_b == 1'b1) rx_q.push_back(rx_b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done_b) n_done_b <= n_done_b + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;

    // Reset values appear before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_ready", rdy_a, 1);
    check("rst_serial", ser_a, 1);
    check("rst_active", act_a, 0);
    check("rst_done", done_a, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single byte 0xA5 from idle.
    clear_cap();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    byte_a = 8'hA5;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    check("t1_line_on_accept_edge", cap_ser[0], 1);
    repeat (50) tick();
    check_frames("t1", 1);

    // Burst of six writes into a depth-4 FIFO: the sixth is dropped.
    clear_cap();
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      byte_a = 8'(k + 1);
      dv_a   = 1'b1;
      tick();
      check($sformatf("t2_ready_after_wr%0d", k + 1), rdy_a, (k < 4) ? 1 : 0);
      if (k < 5) exp_q.push_back(8'(k + 1));
    end
    dv_a = 1'b0;
    repeat (220) tick();
    check_frames("t2", 1);

    // Write presented on the pop edge while full is refused; the next one is taken.
    clear_cap();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      byte_a = 8'h10 + 8'(k);
      dv_a   = 1'b1;
      tick();
      exp_q.push_back(byte_a);
    end
    dv_a  = 1'b0;
    guard = 0;
    while (done_a !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check("t3_first_done_seen", done_a, 1);
    tick();
    byte_a = 8'h77;
    dv_a   = 1'b1;
    check("t3_ready_before_pop", rdy_a, 0);
    tick();
    check("t3_pop_started", ser_a, 0);
    check("t3_ready_after_pop", rdy_a, 1);
    tick();
    dv_a = 1'b0;
    exp_q.push_back(8'h77);
    while (cap_ser.size() < 270) tick();
    check_frames("t3", 1);

    // Reset during data bit 3 of 0x3C with the FIFO full.
    clear_cap();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      byte_a = (k == 0) ? 8'h3C : 8'(k);
      dv_a   = 1'b1;
      tick();
    end
    dv_a = 1'b0;
    check("t4_full_before_rst", rdy_a, 0);
    while (cap_ser.size() < 19) tick();
    check("t4_active_in_bit3", act_a, 1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_serial", ser_a, 1);
    check("t4_rst_ready", rdy_a, 1);
    check("t4_rst_active", act_a, 0);
    check("t4_rst_done", done_a, 0);
    tick();
    tick();
    rst = 1'b0;
    clear_cap();
    exp_q.push_back(8'h81);
    byte_a = 8'h81;
    dv_a   = 1'b1;
    tick();
    dv_a = 1'b0;
    repeat (60) tick();
    check_frames("t4", 1);

    // Loopback at full bit time into the behavioural receiver.
    for (int k = 0; k < 4; k++) begin
      byte_b = lb[k];
      dv_b   = 1'b1;
      tick();
    end
    dv_b  = 1'b0;
    guard = 0;
    while (rx_q.size() < 4 && guard < 20000) begin
      tick();
      guard++;
    end
    check("t5_rx_count", rx_q.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t5_rx%0d", k),
            (rx_q.size() > k) ? {24'h0, rx_q[k]} : 32'hFFFF_FFFF, {24'h0, lb[k]});
    repeat (300) tick();
    check("t5_done_pulses", n_done_b, 4);
    check("t5_line_idle", ser_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises bytes as 8N1 frames: one start bit, 8 data bits LSB first, one stop bit, no parity. A small byte FIFO sits in front of the shifter, so upstream logic can post short bursts without waiting out each frame. It is the transmit half of the board UART link and shares CLKS_PER_BIT and the idle-high line convention with the receive path.

## Interface
- CLKS_PER_BIT, 434: clock cycles per bit (clock frequency / baud rate). Legal range 2..65535.
- FIFO_DEPTH, 4: byte FIFO depth. Power of two, 2..16.
- i_Clock  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  write strobe; the byte is accepted on an edge where i_Tx_DV=1 and o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to send; sampled with i_Tx_DV.
- o_Tx_Ready  out  1  FIFO not full. Reset value 1.
- o_Tx_Serial  out  1  serial line, registered. Reset value 1 (idle high).
- o_Tx_Active  out  1  high while a frame is on the line (START, DATA, STOP). Reset value 0.
- o_Tx_Done  out  1  one-cycle pulse at the end of each stop bit. Reset value 0.

## Operation
- States: IDLE, START, DATA, STOP, CLEANUP. Encoded as 3 bits; unused codes go to IDLE.
- IDLE
  - o_Tx_Serial=1; counter and bit index cleared.
  - If the FIFO is non-empty: pop the head into a shift register, drive o_Tx_Serial<=0, set o_Tx_Active<=1, go to START.
- START: hold 0 for CLKS_PER_BIT cycles, then drive data bit 0 and go to DATA.
- DATA
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - After bit 7, drive 1 and go to STOP.
- STOP
  - Hold 1 for CLKS_PER_BIT cycles.
  - On the last cycle: o_Tx_Done<=1, o_Tx_Active<=0, go to CLEANUP.
- CLEANUP: o_Tx_Done<=0, line stays 1, go to IDLE.
- Counter: 16 bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- FIFO behaviour
  - Write while full is dropped silently; no state changes.
  - A pop and a write on the same edge leave the count unchanged.
  - o_Tx_Ready is derived from the count registered before the edge, so a full FIFO does not accept a write even on the cycle it pops.
- Reset
  - Asserting i_rst at any time, including mid-frame, forces IDLE, empties the FIFO and sets o_Tx_Serial=1 immediately, without waiting for a clock edge.
  - The partial frame is abandoned; no o_Tx_Done pulse is produced.
- The line must never glitch low in IDLE or CLEANUP.

## Timing
- Accept-to-start latency, when idle with an empty FIFO: a byte accepted on edge E0 produces o_Tx_Serial=0 from edge E1.
- Each line level is held exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the stop bit.
- o_Tx_Done is high for exactly 1 cycle, starting on the edge after the final stop-bit cycle.
- Back-to-back frames: successive start bits begin 10*CLKS_PER_BIT+2 cycles apart (one cycle in CLKS_PER_BIT=... CLEANUP, one in IDLE).
- o_Tx_Ready falls on the edge that makes the count equal FIFO_DEPTH, and rises on the edge of the pop that relieves it.

## Structure
- Shared package uart_pkg holds:
  - the state localparams (shared with the receiver);
  - UART_DATA_BITS=8;
  - the counter width constant (16).
- One sub-module, uart_tx_fifo: a synchronous circular FIFO.
  - Parameterised by depth, 8-bit data.
  - Outputs: head data, count, empty, full.
  - Async active-high reset clears the pointers.
- uart_tx instantiates uart_tx_fifo and the shifter/state machine.

## Test plan
- Single byte, CLKS_PER_BIT=4: write 0xA5 while idle.
  - Line from E1 is 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles.
  - o_Tx_Done pulses once, 40 cycles after the start bit begins.
- Burst with FIFO_DEPTH=4: write 0x01..0x06 on 6 consecutive cycles.
  - o_Tx_Ready drops after the 5th write (1 byte in the shifter, 4 in the FIFO).
  - 0x06 is dropped.
  - Frames 0x01..0x05 go out with start bits 42 cycles apart.
- Write on the pop cycle: FIFO full, write 0x77 on the edge the SM pops.
  - The write is rejected.
  - A write of 0x77 on the next cycle (ready=1) is accepted and transmitted last.
- Reset mid-frame: assert i_rst during data bit 3 of 0x3C.
  - o_Tx_Serial=1 and o_Tx_Ready=1 with no clock edge needed.
  - No o_Tx_Done pulse.
  - After release, a new 0x81 is sent cleanly.
- Loopback: drive o_Tx_Serial into the receiver with the same CLKS_PER_BIT (434).
  - Send 0x00, 0xFF, 0x55, 0xAA.
  - The receiver reports the identical bytes, each with one valid pulse.
